// File: rtl/opl_header_parser.sv
// Ingress parser for the OPL action processor: forwards every word to the packet
// FIFO one cycle later and emits one {pkt_size, ttl, aps} result plus one AP lookup per packet.
module opl_header_parser #(
  parameter int                    DATA_WIDTH       = 64,
  parameter int                    CTRL_WIDTH       = DATA_WIDTH / 8,
  parameter int                    PKT_SIZE_WIDTH   = 12,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM    = CTRL_WIDTH'(8'hFF),
  parameter int                    IOQ_BYTE_LEN_POS = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic                             in_wr,
  output logic                             in_rdy,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0] pkt_fifo_din,
  output logic                             pkt_fifo_wr_en,
  input  logic                             pkt_fifo_nearly_full,
  output logic [PKT_SIZE_WIDTH+15:0]       result_din,
  output logic                             result_wr_en,
  input  logic                             result_fifo_nearly_full,
  output logic                             lookup_req,
  output logic [31:0]                      lookup_ap,
  output logic [31:0]                      pkt_cnt,
  output logic [15:0]                      err_cnt
);

  typedef enum logic [1:0] {
    HDRS    = 2'd0,
    FIRST   = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [PKT_SIZE_WIDTH-1:0]          len_q, len_d;
  logic                               hdr_seen_q, hdr_seen_d;
  logic                               in_rdy_q, in_rdy_d;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0]   pkt_fifo_din_q, pkt_fifo_din_d;
  logic                               pkt_fifo_wr_en_q, pkt_fifo_wr_en_d;
  logic [PKT_SIZE_WIDTH+15:0]         result_din_q, result_din_d;
  logic                               result_wr_en_q, result_wr_en_d;
  logic                               lookup_req_q, lookup_req_d;
  logic [31:0]                        lookup_ap_q, lookup_ap_d;
  logic [31:0]                        pkt_cnt_q, pkt_cnt_d;
  logic [15:0]                        err_cnt_q, err_cnt_d;

  logic        ctrl_zero;
  logic        first_word;
  logic        ioq_hdr;
  logic        eop_word;
  logic [15:0] byte_len;

  assign ctrl_zero = (in_ctrl == '0);
  assign byte_len  = in_data[IOQ_BYTE_LEN_POS +: 16];
  // The first data word is recognised straight from HDRS, so FIRST is never resident.
  assign first_word = in_wr && (((state_q == HDRS) && ctrl_zero) || (state_q == FIRST));
  assign ioq_hdr    = in_wr && (state_q == HDRS) && (in_ctrl == IOQ_STAGE_NUM);
  assign eop_word   = in_wr && (state_q == PAYLOAD) && !ctrl_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= HDRS;
      len_q            <= '0;
      hdr_seen_q       <= 1'b0;
      in_rdy_q         <= 1'b0;
      pkt_fifo_din_q   <= '0;
      pkt_fifo_wr_en_q <= 1'b0;
      result_din_q     <= '0;
      result_wr_en_q   <= 1'b0;
      lookup_req_q     <= 1'b0;
      lookup_ap_q      <= '0;
      pkt_cnt_q        <= '0;
      err_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      hdr_seen_q       <= hdr_seen_d;
      in_rdy_q         <= in_rdy_d;
      pkt_fifo_din_q   <= pkt_fifo_din_d;
      pkt_fifo_wr_en_q <= pkt_fifo_wr_en_d;
      result_din_q     <= result_din_d;
      result_wr_en_q   <= result_wr_en_d;
      lookup_req_q     <= lookup_req_d;
      lookup_ap_q      <= lookup_ap_d;
      pkt_cnt_q        <= pkt_cnt_d;
      err_cnt_q        <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_wr) begin
      case (state_q)
        HDRS:    if (ctrl_zero) state_d = PAYLOAD;
        FIRST:   state_d = PAYLOAD;
        PAYLOAD: if (!ctrl_zero) state_d = HDRS;
        default: state_d = HDRS;
      endcase
    end
  end

  always_comb begin
    len_d            = len_q;
    hdr_seen_d       = hdr_seen_q;
    in_rdy_d         = !pkt_fifo_nearly_full && !result_fifo_nearly_full;
    pkt_fifo_din_d   = pkt_fifo_din_q;
    pkt_fifo_wr_en_d = in_wr;
    result_din_d     = result_din_q;
    result_wr_en_d   = 1'b0;
    lookup_req_d     = 1'b0;
    lookup_ap_d      = lookup_ap_q;
    pkt_cnt_d        = pkt_cnt_q;
    err_cnt_d        = err_cnt_q;

    if (in_wr) begin
      pkt_fifo_din_d = {in_ctrl, in_data};
    end

    // Later IOQ headers overwrite earlier ones; the length is truncated to the result field.
    if (ioq_hdr) begin
      len_d      = byte_len[PKT_SIZE_WIDTH-1:0];
      hdr_seen_d = 1'b1;
    end

    if (first_word) begin
      result_din_d   = {(hdr_seen_q ? len_q : {PKT_SIZE_WIDTH{1'b0}}),
                        in_data[DATA_WIDTH-1 -: 8], in_data[DATA_WIDTH-9 -: 8]};
      result_wr_en_d = 1'b1;
      lookup_ap_d    = in_data[DATA_WIDTH-17 -: 32];
      lookup_req_d   = 1'b1;
      pkt_cnt_d      = pkt_cnt_q + 32'd1;
      if (!hdr_seen_q && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end

    if (eop_word) begin
      hdr_seen_d = 1'b0;
    end
  end

  assign in_rdy         = in_rdy_q;
  assign pkt_fifo_din   = pkt_fifo_din_q;
  assign pkt_fifo_wr_en = pkt_fifo_wr_en_q;
  assign result_din     = result_din_q;
  assign result_wr_en   = result_wr_en_q;
  assign lookup_req     = lookup_req_q;
  assign lookup_ap      = lookup_ap_q;
  assign pkt_cnt        = pkt_cnt_q;
  assign err_cnt        = err_cnt_q;

endmodule
